repeat_buffer_arbiter: RTL

- Shares one unpacked_repeat_circular_buffer instance between two streaming requesters on a frame basis.
- A frame is SIZE beats written into the buffer. The buffer replays that frame REPEAT times, so it emits SIZE*REPEAT beats.
- The arbiter holds a grant until the whole replayed frame has left the buffer, then re-arbitrates round-robin.
- It tags each output beat with its owning requester and a last-beat flag. Typical use: alternating activation/weight tiles into a shared replay buffer in front of a matmul.

---
 rtl/repeat_arb_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/repeat_buffer_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/repeat_arb_pkg.sv
// Shared types for the repeat-buffer arbiter: frame FSM states and requester id.
package repeat_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the registered last_grant decides ties and is
// updated by the caller when a granted transaction finishes.
module rr_arbiter2
    import repeat_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req0_i,
    input  logic    req1_i,
    input  logic    update_i,
    input  req_id_t update_id_i,
    output logic    grant_valid_o,
    output req_id_t grant_id_o
);

    req_id_t last_grant_q;
    req_id_t last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (update_i) begin
            last_grant_d = update_id_i;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_id_o    = (req0_i && req1_i) ? ~last_grant_q : req1_i;
    end

endmodule

// File: rtl/repeat_buffer_arbiter.sv
// Frame-granular arbiter sharing one repeat/replay buffer between two streams;
// a grant is held until all SIZE*REPEAT replayed beats have left the buffer.
module repeat_buffer_arbiter
    import repeat_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_NUM     = 1,
    parameter int REPEAT     = 2,
    parameter int SIZE       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req0_data [IN_NUM-1:0],
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req1_data [IN_NUM-1:0],
    input  logic                  req1_valid,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] buf_in_data [IN_NUM-1:0],
    output logic                  buf_in_valid,
    input  logic                  buf_in_ready,
    input  logic                  buf_out_valid,
    input  logic                  buf_out_ready,
    output logic                  out_owner,
    output logic                  out_last,
    output logic                  busy,
    output arb_state_e            dbg_state
);

    localparam int TOTAL = SIZE * REPEAT;
    localparam int IN_W  = $clog2(SIZE + 1);
    localparam int OUT_W = $clog2(TOTAL + 1);
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(SIZE - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(TOTAL - 1);

    arb_state_e       state_q, state_d;
    req_id_t          owner_q, owner_d;
    logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic             frame_done;
    logic             grant_valid;
    req_id_t          grant_id;

    rr_arbiter2 u_rr (
        .clk           (clk),
        .rst           (rst),
        .req0_i        (req0_valid),
        .req1_i        (req1_valid),
        .update_i      (frame_done),
        .update_id_i   (owner_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            buf_in_data[i] = owner_q ? req1_data[i] : req0_data[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        frame_done   = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        buf_in_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = FILL;
                    owner_d = grant_id;
                end
            end
            FILL: begin
                buf_in_valid = owner_q ? req1_valid : req0_valid;
                req0_ready   = !owner_q && buf_in_ready;
                req1_ready   = owner_q && buf_in_ready;
                if (buf_in_valid && buf_in_ready) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_W'(1);
                    end
                end
            end
            DRAIN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The buffer starts replaying pass 0 while still filling, so count in FILL too.
        if ((state_q != IDLE) && buf_out_valid && buf_out_ready) begin
            if (out_cnt_q == OUT_LAST) begin
                frame_done = 1'b1;
                out_cnt_d  = '0;
                state_d    = IDLE;
            end else begin
                out_cnt_d = out_cnt_q + OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // A frame can only finish before it is fully written if the buffer misbehaves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(frame_done && state_q == FILL));
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_owner = owner_q;
    assign out_last  = busy && buf_out_valid && (out_cnt_q == OUT_LAST);
    assign dbg_state = state_q;

endmodule
